reg_share_arbiter: RTL and testbench

//   Shares one W-bit edge-triggered storage register (flip-flop bank) between N

---
 rtl/reg_share_pkg.sv | 17 +
 rtl/rr_pick.sv | 38 +++
 rtl/reg_share_arbiter.sv | 122 ++++++++++++
 tb/tb_reg_share_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/reg_share_pkg.sv
// rtl/reg_share_pkg.sv - shared types and defaults for the shared-register arbiter
// Contents:
//   state_t  transaction FSM state (IDLE, GRANT, DONE)
//   N_DEF    default requester count
//   W_DEF    default shared register width
package reg_share_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int N_DEF = 4;
   localparam int W_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
// Ports:
//   req  in   N      request vector
//   ptr  in   IW     index with highest priority this round
//   win  out  IW     first requester at or after ptr, wrapping N-1 -> 0
//   any  out  1      at least one request bit is set
module rr_pick
   import reg_share_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] win,
   output logic                 any
);

   localparam int IW = $clog2(N);

   always_comb begin
      win = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         automatic int          j     = int'(ptr) + i;
         automatic logic [IW-1:0] j_idx;
         if (j >= N) begin
            j = j - N;
         end
         j_idx = IW'(j);
         // The first hit in scan order wins; later hits are ignored.
         if (!any && req[j_idx]) begin
            any = 1'b1;
            win = j_idx;
         end
      end
   end

endmodule

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - round-robin arbiter sharing one W-bit register among N requesters
// Ports:
//   CK       in   1    clock, rising edge
//   RST      in   1    synchronous active-high reset
//   REQ      in   N    level-held request, one bit per requester
//   WDATA    in   N*W  write data, requester i on bits [i*W +: W]
//   GNT      out  N    one-hot grant, registered
//   ACK      out  N    one-hot one-cycle write-done pulse, registered
//   Q        out  W    shared register contents
//   Q_VALID  out  1    Q written at least once since reset
//   BUSY     out  1    transaction in progress (GRANT or DONE)
module reg_share_arbiter
   import reg_share_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic           CK,
   input  logic           RST,
   input  logic [N-1:0]   REQ,
   input  logic [N*W-1:0] WDATA,
   output logic [N-1:0]   GNT,
   output logic [N-1:0]   ACK,
   output logic [W-1:0]   Q,
   output logic           Q_VALID,
   output logic           BUSY
);

   localparam int            IW       = $clog2(N);
   localparam logic [N-1:0]  ONE_HOT0 = N'(1);

   state_t          state_q, state_d;
   logic [IW-1:0]   win_q, win_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [N-1:0]    ack_q, ack_d;
   logic [W-1:0]    q_q, q_d;
   logic            q_valid_q, q_valid_d;
   logic            busy_q, busy_d;

   logic [IW-1:0]   pick_win;
   logic            pick_any;

   rr_pick #(
      .N (N)
   ) u_rr_pick (
      .req (REQ),
      .ptr (ptr_q),
      .win (pick_win),
      .any (pick_any)
   );

   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      ptr_d     = ptr_q;
      gnt_d     = '0;
      ack_d     = '0;
      q_d       = q_q;
      q_valid_d = q_valid_q;
      busy_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = GRANT;
               win_d   = pick_win;
               gnt_d   = ONE_HOT0 << pick_win;
               busy_d  = 1'b1;
            end
         end
         GRANT: begin
            // A winner that withdraws while granted aborts: no write, and the
            // pointer stays so the same ranking applies next round.
            if (REQ[win_q]) begin
               state_d   = DONE;
               q_d       = WDATA[int'(win_q)*W +: W];
               q_valid_d = 1'b1;
               ptr_d     = (win_q == IW'(N-1)) ? '0 : win_q + 1'b1;
               ack_d     = ONE_HOT0 << win_q;
               busy_d    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         state_q   <= IDLE;
         win_q     <= '0;
         ptr_q     <= '0;
         gnt_q     <= '0;
         ack_q     <= '0;
         q_q       <= '0;
         q_valid_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
         busy_q    <= busy_d;
      end
   end

   assign GNT     = gnt_q;
   assign ACK     = ack_q;
   assign Q       = q_q;
   assign Q_VALID = q_valid_q;
   assign BUSY    = busy_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb/tb_reg_share_arbiter.sv - directed self-checking bench for reg_share_arbiter
module tb_reg_share_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           CK;
   logic           RST;
   logic [N-1:0]   REQ;
   logic [N*W-1:0] WDATA;
   logic [N-1:0]   GNT;
   logic [N-1:0]   ACK;
   logic [W-1:0]   Q;
   logic           Q_VALID;
   logic           BUSY;

   int pass_cnt;
   int total_cnt;

   reg_share_arbiter #(
      .N (N),
      .W (W)
   ) dut (
      .CK      (CK),
      .RST     (RST),
      .REQ     (REQ),
      .WDATA   (WDATA),
      .GNT     (GNT),
      .ACK     (ACK),
      .Q       (Q),
      .Q_VALID (Q_VALID),
      .BUSY    (BUSY)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled and inputs changed 1ns later.
   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " gnt"},  32'(GNT),  32'h0);
      check({tag, " ack"},  32'(ACK),  32'h0);
      check({tag, " busy"}, 32'(BUSY), 32'h0);
   endtask

   logic [7:0] fair_order [5];

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      RST   = 1'b1;
      REQ   = 4'b1111;
      WDATA = '0;
      for (int i = 0; i < N; i++) begin
         WDATA[i*W +: W] = 8'(8'h11 * i);
      end

      // Reset held two cycles with all requests up
      tick();
      tick();
      check_idle("reset");
      check("reset q",  32'(Q),       32'h00);
      check("reset qv", 32'(Q_VALID), 32'h0);

      RST = 1'b0;
      REQ = 4'b0000;
      tick();
      check_idle("post-reset idle");

      // Single write from requester 0
      WDATA[0 +: W] = 8'hA5;
      REQ = 4'b0001;
      tick();
      check("single gnt",  32'(GNT),  32'h1);
      check("single ack0", 32'(ACK),  32'h0);
      check("single busy", 32'(BUSY), 32'h1);
      check("single q pre", 32'(Q),   32'h00);
      tick();
      check("single ack",  32'(ACK),     32'h1);
      check("single gnt0", 32'(GNT),     32'h0);
      check("single q",    32'(Q),       32'hA5);
      check("single qv",   32'(Q_VALID), 32'h1);
      check("single busy done", 32'(BUSY), 32'h1);
      REQ = 4'b0000;
      tick();
      check_idle("single end");
      check("single q hold", 32'(Q), 32'hA5);

      // Fairness from a fresh pointer
      RST = 1'b1;
      tick();
      RST = 1'b0;
      WDATA[0 +: W] = 8'h00;
      fair_order[0] = 8'd0;
      fair_order[1] = 8'd1;
      fair_order[2] = 8'd2;
      fair_order[3] = 8'd3;
      fair_order[4] = 8'd0;
      REQ = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         tick();
         check($sformatf("fair%0d gnt", t), 32'(GNT), 32'(4'b0001 << fair_order[t]));
         check($sformatf("fair%0d noack", t), 32'(ACK), 32'h0);
         tick();
         check($sformatf("fair%0d ack", t), 32'(ACK), 32'(4'b0001 << fair_order[t]));
         check($sformatf("fair%0d q", t),   32'(Q),   32'(8'h11 * fair_order[t]));
         check($sformatf("fair%0d nognt", t), 32'(GNT), 32'h0);
         tick();
         check($sformatf("fair%0d idle ack", t), 32'(ACK), 32'h0);
         check($sformatf("fair%0d idle gnt", t), 32'(GNT), 32'h0);
      end
      REQ = 4'b0000;
      tick();
      check_idle("fair end");

      // Abort: requester 2 withdraws while granted (pointer is 1 here)
      REQ = 4'b0100;
      tick();
      check("abort gnt", 32'(GNT), 32'h4);
      REQ = 4'b0000;
      tick();
      check_idle("abort");
      check("abort q", 32'(Q), 32'h00);
      REQ = 4'b0110;
      tick();
      check("abort next gnt", 32'(GNT), 32'h2);
      tick();
      check("abort next ack", 32'(ACK), 32'h2);
      check("abort next q",   32'(Q),   32'h11);
      REQ = 4'b0000;
      tick();

      // Reset during the GRANT cycle
      REQ = 4'b0001;
      tick();
      check("midrst gnt", 32'(GNT), 32'h1);
      RST = 1'b1;
      tick();
      check_idle("midrst");
      check("midrst q",  32'(Q),       32'h00);
      check("midrst qv", 32'(Q_VALID), 32'h0);
      RST = 1'b0;
      REQ = 4'b0000;
      tick();
      check_idle("midrst after");
      check("midrst q after", 32'(Q), 32'h00);

      // Wrap: requester 3 completes, pointer wraps to 0
      REQ = 4'b1000;
      tick();
      check("wrap gnt3", 32'(GNT), 32'h8);
      tick();
      check("wrap ack3", 32'(ACK), 32'h8);
      check("wrap q3",   32'(Q),   32'h33);
      REQ = 4'b0000;
      tick();
      REQ = 4'b1001;
      tick();
      check("wrap gnt0", 32'(GNT), 32'h1);
      tick();
      check("wrap ack0", 32'(ACK), 32'h1);
      check("wrap q0",   32'(Q),   32'h00);
      // Held request re-ranked by the advanced pointer
      tick();
      check("wrap idle", 32'(GNT), 32'h0);
      tick();
      check("wrap held gnt3", 32'(GNT), 32'h8);
      tick();
      check("wrap held ack3", 32'(ACK), 32'h8);
      REQ = 4'b0000;
      tick();
      check_idle("wrap end");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
